// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller: PC select codes, widths and fetch states.
// Also provides the redirect decode so every user agrees on what counts as a jump.
package pc_fetch_ctrl_pkg;

  localparam int WIDTH_PCSEL = 2;
  localparam logic [WIDTH_PCSEL-1:0] PCSEL_PC4  = 2'd0;
  localparam logic [WIDTH_PCSEL-1:0] PCSEL_JUMP = 2'd1;

  localparam int WIDTH_PC = 32;

  typedef enum logic [1:0] {
    FST_BOOT = 2'd0,
    FST_REQ  = 2'd1,
    FST_WAIT = 2'd2,
    FST_DROP = 2'd3
  } fetch_state_e;

  // Every encoding other than PCSEL_JUMP continues sequential fetch.
  function automatic logic is_redirect(input logic [WIDTH_PCSEL-1:0] sel);
    return sel == PCSEL_JUMP;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_gen.sv
// Next fetch-PC selection: aligned redirect target, pc+4 on an accepted request, else hold.
// Misalignment is flagged combinationally whenever an enabled redirect has nonzero low bits.
module pc_fetch_ctrl_pc_next_gen #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] i_pc_q,
  input  logic [PC_W-1:0] i_branch_pc,
  input  logic            i_redirect,
  input  logic            i_advance,
  output logic [PC_W-1:0] o_pc_next,
  output logic            o_misalign
);

  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_plus4;

  assign w_target   = {i_branch_pc[PC_W-1:2], 2'b00};
  assign w_pc_plus4 = i_pc_q + PC_W'(4);

  // A redirect wins over +4 when both happen in the same cycle.
  always_comb begin
    o_pc_next = i_pc_q;
    if (i_redirect) begin
      o_pc_next = w_target;
    end else if (i_advance) begin
      o_pc_next = w_pc_plus4;
    end
  end

  assign o_misalign = i_redirect && (i_branch_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-PC owner: single-outstanding instruction-memory requests, IF/ID output register,
// and redirect handling that drops wrong-path responses and flushes IF/ID.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH_PCSEL-1:0] pc_sel,
  input  logic [PC_W-1:0]        branch_pc,
  input  logic                   stall,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INST_W-1:0]      imem_rdata,
  output logic                   if_valid,
  output logic [PC_W-1:0]        if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   flush_id,
  output logic                   misalign
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [PC_W-1:0]   r_pc_q;
  logic [PC_W-1:0]   r_req_pc;
  logic              r_if_valid;
  logic [PC_W-1:0]   r_if_pc;
  logic [INST_W-1:0] r_if_inst;
  logic              r_flush_id;

  logic [PC_W-1:0] w_pc_next;
  logic            w_misalign;
  logic            w_redirect;
  logic            w_hold;
  logic            w_req;
  logic            w_fire;
  logic            w_accept;

  // Redirects are ignored while booting; the first fetch always uses RESET_PC.
  assign w_redirect = is_redirect(pc_sel) && (r_state != FST_BOOT);
  assign w_hold     = stall && r_if_valid;
  assign w_req      = (r_state == FST_REQ) && !w_hold;
  assign w_fire     = w_req && imem_gnt;
  assign w_accept   = (r_state == FST_WAIT) && imem_rvalid && !w_redirect;

  pc_fetch_ctrl_pc_next_gen #(
    .PC_W (PC_W)
  ) u_pc_next_gen (
    .i_pc_q      (r_pc_q),
    .i_branch_pc (branch_pc),
    .i_redirect  (w_redirect),
    .i_advance   (w_fire),
    .o_pc_next   (w_pc_next),
    .o_misalign  (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DROP leaves on its rvalid even if another redirect lands that cycle: nothing is outstanding.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FST_BOOT: w_state_next = FST_REQ;
      FST_REQ: begin
        if (w_redirect) begin
          w_state_next = w_fire ? FST_DROP : FST_REQ;
        end else if (w_fire) begin
          w_state_next = FST_WAIT;
        end
      end
      FST_WAIT: begin
        if (imem_rvalid) begin
          w_state_next = FST_REQ;
        end else if (w_redirect) begin
          w_state_next = FST_DROP;
        end
      end
      FST_DROP: begin
        if (imem_rvalid) begin
          w_state_next = FST_REQ;
        end
      end
      default: w_state_next = FST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_q     <= RESET_PC;
      r_req_pc   <= '0;
      r_flush_id <= 1'b0;
    end else begin
      r_pc_q     <= w_pc_next;
      r_flush_id <= w_redirect;
      if (w_fire) begin
        r_req_pc <= r_pc_q;
      end
    end
  end

  // IF/ID output: load on an accepted response, hold only while stalled, otherwise consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else begin
      if (w_accept) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_req_pc;
        r_if_inst  <= imem_rdata;
      end else if (w_redirect || !w_hold) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc_q;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;
  assign flush_id  = r_flush_id;
  assign misalign  = w_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: a memory responder plus a program-order reference model
// that tracks the expected fetch stream, live/killed requests and the IF/ID contents.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          N_CYC  = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic [31:0] branch_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush_id;
  logic        misalign;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .PC_W     (32),
    .INST_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_sel      (pc_sel),
    .branch_pc   (branch_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .flush_id    (flush_id),
    .misalign    (misalign)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference model: architectural view of fetch, independent of any state encoding.
  logic        m_if_valid;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic [31:0] exp_pc;
  logic        live;
  logic [31:0] live_pc;
  logic        exp_flush;
  logic        boot;
  logic        stale;

  // Memory responder: one response per grant, 1..3 cycles after it; survives reset.
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_flush_id", 32'(flush_id), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    m_if_valid = 1'b0;
    m_if_pc    = '0;
    m_if_inst  = '0;
    exp_pc     = RST_PC;
    live       = 1'b0;
    live_pc    = '0;
    exp_flush  = 1'b0;
    boot       = 1'b1;
    stale      = pend;
  endtask

  initial begin
    logic        redirect;
    logic        grant;
    logic        delivered;
    logic [31:0] tgt;
    logic [31:0] rnd;
    int          r;
    logic        did_mid;

    rst_n       = 1'b1;
    pc_sel      = PCSEL_PC4;
    branch_pc   = '0;
    stall       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend        = 1'b0;
    pend_cnt    = 0;
    pend_addr   = '0;
    stale       = 1'b0;
    did_mid     = 1'b0;
    #1;
    do_reset();

    for (int it = 0; it < N_CYC; it++) begin
      stall = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 19));
      if (r < 2)       pc_sel = PCSEL_JUMP;
      else if (r == 2) pc_sel = 2'd3;
      else             pc_sel = PCSEL_PC4;
      rnd = $urandom;
      if ($urandom_range(0, 5) == 0) branch_pc = 32'hFFFF_FFF0 | (rnd & 32'h0000_000F);
      else                           branch_pc = rnd & 32'h0000_0FFF;
      imem_rvalid = pend && (pend_cnt == 0);
      imem_rdata  = imem_rvalid ? mem_word(pend_addr) : $urandom;
      #1;
      imem_gnt = imem_req && !pend && ($urandom_range(0, 9) < 7);
      #1;

      redirect = (pc_sel == PCSEL_JUMP) && !boot;
      tgt      = branch_pc & 32'hFFFF_FFFC;
      if (boot) begin
        check("req_boot", 32'(imem_req), 32'd0);
      end else if (!pend) begin
        check("req_idle", 32'(imem_req), 32'(!(stall && m_if_valid)));
      end else if (!stale) begin
        check("req_outstanding", 32'(imem_req), 32'd0);
      end
      if (imem_req) check("imem_addr", imem_addr, exp_pc);
      check("misalign", 32'(misalign), 32'(redirect && (tgt != branch_pc)));

      grant     = imem_req && imem_gnt;
      delivered = imem_rvalid && live && !redirect;
      if (delivered) begin
        m_if_valid = 1'b1;
        m_if_pc    = live_pc;
        m_if_inst  = mem_word(live_pc);
      end else if (redirect || !(stall && m_if_valid)) begin
        m_if_valid = 1'b0;
      end
      if (imem_rvalid) live = 1'b0;
      if (grant) begin
        live    = !redirect;
        live_pc = imem_addr;
      end
      if (redirect) begin
        live   = 1'b0;
        exp_pc = tgt;
      end else if (grant) begin
        exp_pc = exp_pc + 32'd4;
      end
      exp_flush = redirect;
      boot      = 1'b0;

      if (imem_rvalid) begin
        pend  = 1'b0;
        stale = 1'b0;
      end else if (pend && pend_cnt > 0) begin
        pend_cnt--;
      end
      if (grant) begin
        pend      = 1'b1;
        pend_cnt  = int'($urandom_range(0, 2));
        pend_addr = imem_addr;
      end

      @(negedge clk);
      check("if_valid", 32'(if_valid), 32'(m_if_valid));
      if (m_if_valid) begin
        check("if_pc", if_pc, m_if_pc);
        check("if_inst", if_inst, m_if_inst);
      end
      check("flush_id", 32'(flush_id), 32'(exp_flush));

      // Reset while a request is in flight so its response lands after release.
      if (!did_mid && it > 1200 && pend) begin
        did_mid = 1'b1;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Consumes the branch-resolution outputs (PC select and branch target) and owns the architectural fetch PC. It issues single-outstanding requests to instruction memory and presents fetched instructions to the IF/ID register. On a taken branch or jump it redirects fetch, discards wrong-path responses and flushes the wrong-path instruction in IF/ID.

Parameters:
PC_W, 32, width of PC and instruction-memory address
INST_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_sel  input  WIDTH_PCSEL  PCSEL_JUMP = redirect; PCSEL_PC4 = sequential
branch_pc  input  PC_W  redirect target, valid when pc_sel==PCSEL_JUMP
stall  input  1  hazard stall from ID; hold IF output and issue no new request
imem_req  output  1  fetch request
imem_addr  output  PC_W  fetch address, stable while imem_req=1 and gnt=0
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid; at most one per granted request, no earlier than the cycle after gnt
imem_rdata  input  INST_W  fetched instruction
if_valid  output  1  if_inst/if_pc hold a valid instruction
if_pc  output  PC_W  address of if_inst
if_inst  output  INST_W  instruction to IF/ID
flush_id  output  1  one-cycle pulse; kill the instruction in IF/ID
misalign  output  1  one-cycle pulse; branch_pc[1:0]!=0 on redirect

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc_q=RESET_PC. imem_req, if_valid, flush_id and misalign are 0. if_pc and if_inst are 0.
- States:
  - BOOT: go to REQ after one cycle.
  - REQ: drive imem_req=1 and imem_addr=pc_q, unless stall=1 and if_valid=1.
  - WAIT: one request is outstanding.
  - DROP: the outstanding response is wrong-path.
- REQ, no redirect: on imem_req&imem_gnt, latch req_pc=pc_q, set pc_q<=pc_q+4 (mod 2^PC_W, wraps silently) and go to WAIT.
- WAIT: on imem_rvalid, load if_inst=imem_rdata, if_pc=req_pc, if_valid=1, then go to REQ. Fetch-to-IF latency is gnt + 1 cycle minimum.
- Stall handling: while stall=1 and if_valid=1, if_* are held unchanged and no new request is issued. A response arriving in WAIT while stall=1 and if_valid=1 is impossible by construction.
- When stall=0, the IF/ID register consumes if_* each cycle. If no new response arrives, if_valid<=0.
- Redirect definition: redirect = (pc_sel==PCSEL_JUMP). Redirect overrides stall.
- On redirect in any state except BOOT:
  - pc_q<=branch_pc with bits [1:0] forced to 0.
  - misalign pulses if either of those bits was 1.
  - flush_id pulses in the next cycle.
  - if_valid<=0.
- Next state after a redirect:
  - from REQ with no grant this cycle: stay in REQ. imem_addr changes to the new target next cycle. The ungranted request is withdrawn, which is legal.
  - from REQ with grant in the same cycle: go to DROP. The target wins over +4.
  - from WAIT with no rvalid: go to DROP.
  - from WAIT with rvalid in the same cycle: discard the response and go to REQ.
  - from DROP: stay in DROP, and only pc_q updates.
- DROP: imem_req=0. On imem_rvalid, discard the data, keep if_valid=0 and go to REQ.
- Redirect-to-request latency: first imem_req with the target is 1 cycle after the redirect when no request is outstanding; otherwise it is the cycle after the dropped rvalid.
- A redirect during BOOT is ignored.
- Reset asserted mid-request: the state returns to BOOT. A late imem_rvalid in BOOT or REQ is ignored.
- Back-to-back redirects: the last target wins, and flush_id pulses for each one.

Decomposition:
- Shared header: PCSEL_PC4 / PCSEL_JUMP encodings and WIDTH_PCSEL, already present.
- New in the same header: WIDTH_PC and fetch state encodings FST_BOOT / FST_REQ / FST_WAIT / FST_DROP, 2-bit.
- Natural sub-module: pc_next_gen, combinational. It selects among pc_q+4, the aligned branch_pc and hold, and generates misalign.

Test Plan:
- Reset release with gnt tied 1 and rvalid one cycle after gnt -> imem_addr sequence 0x0,0x4,0x8; if_pc follows one cycle behind gnt; if_valid=1.
- stall=1 for 3 cycles while if_valid=1 at if_pc=0x8 -> if_* held and imem_req=0; fetch of 0xC resumes the cycle after stall falls.
- Redirect to 0x100 while in WAIT for 0x10 -> response for 0x10 discarded; flush_id pulses once; next imem_addr=0x100; if_pc=0x100 after its rvalid.
- Redirect to 0x200 in the same cycle as gnt for 0x14 -> DROP state; pc_q=0x200 (not 0x18); data for 0x14 never appears on if_*.
- Redirect with branch_pc=0x303 -> misalign pulses 1 cycle; fetch address 0x300.
- rst_n asserted while in WAIT, late rvalid after release -> ignored; first fetch is RESET_PC.
